// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: widths, ALU op codes, FSM states
// and the writeback-forwarding hit test used when ISSUE_BYPASS_EN is defined.
package alu_issue_pkg;

    localparam int DW    = 8;
    localparam int NREGS = 8;
    localparam int AW    = $clog2(NREGS);

    // Op code 3'b101 is deliberately left out: it is forwarded untouched to the ALU.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b110,
        OP_BZ  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } issue_state_e;

    // True when a source index names the register that is retiring this cycle.
    function automatic logic fwd_hit(
        input logic [AW-1:0] src,
        input logic [AW-1:0] rd,
        input logic          wb
    );
        return wb && (rd != '0) && (src == rd);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side bus of the ALU issue stage: instruction handshake in, result pulse out.
// master = decode/consumer side, slave = the issue stage.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic            ins_valid;
    logic            ins_ready;
    logic [2:0]      ins_op;
    logic [AW-1:0]   ins_rs;
    logic [AW-1:0]   ins_rt;
    logic [DW-1:0]   ins_imm;
    logic            ins_use_imm;
    logic [AW-1:0]   ins_rd;
    logic            ins_wb;

    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic            res_zero;
    logic [AW-1:0]   res_rd;

    modport master (
        output ins_valid, ins_op, ins_rs, ins_rt, ins_imm, ins_use_imm, ins_rd, ins_wb,
        input  ins_ready, res_valid, res_data, res_zero, res_rd
    );

    modport slave (
        input  ins_valid, ins_op, ins_rs, ins_rt, ins_imm, ins_use_imm, ins_rd, ins_wb,
        output ins_ready, res_valid, res_data, res_zero, res_rd
    );

endinterface

// File: rtl/alu_issue_regfile.sv
// gcore_regfile: NREGS x DW architectural registers, two asynchronous read
// ports, one synchronous write port, R0 hardwired to zero, synchronous reset.
module gcore_regfile
    import alu_issue_pkg::*;
#(
    parameter int P_DW    = DW,
    parameter int P_NREGS = NREGS,
    parameter int P_AW    = AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [P_AW-1:0]   ra_idx,
    output logic [P_DW-1:0]   ra_data,
    input  logic [P_AW-1:0]   rb_idx,
    output logic [P_DW-1:0]   rb_data,
    input  logic              we,
    input  logic [P_AW-1:0]   wa,
    input  logic [P_DW-1:0]   wd
);

    logic [P_DW-1:0] regs_q [P_NREGS];
    logic [P_DW-1:0] regs_d [P_NREGS];

    // Next register contents: a single write per cycle, writes to R0 dropped.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
    end

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = (ra_idx == '0) ? '0 : regs_q[ra_idx];
    assign rb_data = (rb_idx == '0) ? '0 : regs_q[rb_idx];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: operand-issue / writeback stage wrapped around the 8-bit registered ALU.
// IDLE -> EXEC -> WB -> IDLE; result reported two cycles after acceptance.
// Optional feature macro: ISSUE_BYPASS_EN (accept in WB, forward retiring result).
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_issue_if.slave       bus,
    output logic [2:0]       alu_op,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic [DW-1:0]    alu_ans,
    input  logic             alu_zero
);

    issue_state_e    state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            wb_q, wb_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;

    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_data_q, res_data_d;
    logic            res_zero_q, res_zero_d;
    logic [AW-1:0]   res_rd_q, res_rd_d;

    logic [DW-1:0]   rf_data_a;
    logic [DW-1:0]   rf_data_b;
    logic [DW-1:0]   src_a;
    logic [DW-1:0]   src_rt;
    logic [DW-1:0]   src_b;
    logic            ins_ready;
    logic            accept;
    logic            rf_we;

    gcore_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_idx  (bus.ins_rs),
        .ra_data (rf_data_a),
        .rb_idx  (bus.ins_rt),
        .rb_data (rf_data_b),
        .we      (rf_we),
        .wa      (rd_q),
        .wd      (alu_ans)
    );

`ifdef ISSUE_BYPASS_EN
    // A new instruction may enter while the previous one retires; any source
    // naming the retiring rd must see the ALU result, not the stale register.
    logic fwd_a;
    logic fwd_b;

    assign ins_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign fwd_a     = (state_q == ST_WB) && fwd_hit(bus.ins_rs, rd_q, wb_q);
    assign fwd_b     = (state_q == ST_WB) && fwd_hit(bus.ins_rt, rd_q, wb_q);
    assign src_a     = fwd_a ? alu_ans : rf_data_a;
    assign src_rt    = fwd_b ? alu_ans : rf_data_b;
`else
    assign ins_ready = (state_q == ST_IDLE);
    assign src_a     = rf_data_a;
    assign src_rt    = rf_data_b;
`endif

    assign src_b  = bus.ins_use_imm ? bus.ins_imm : src_rt;
    assign accept = bus.ins_valid && ins_ready;

    // The register file only changes while an instruction is retiring.
    assign rf_we = (state_q == ST_WB) && wb_q && (rd_q != '0);

    // Next-state and next-output computation for the issue FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        wb_d        = wb_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_rd_d    = res_rd_q;

        case (state_q)
            ST_EXEC: begin
                state_d     = ST_WB;
                res_valid_d = 1'b1;
                res_rd_d    = rd_q;
            end
            ST_WB: begin
                state_d    = ST_IDLE;
                res_data_d = alu_ans;
                res_zero_d = alu_zero;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_EXEC;
            op_d    = bus.ins_op;
            rd_d    = bus.ins_rd;
            wb_d    = bus.ins_wb;
            a_d     = src_a;
            b_d     = src_b;
        end
    end

    // FSM and all registered outputs; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            rd_q        <= '0;
            wb_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            wb_q        <= wb_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_rd_q    <= res_rd_d;
        end
    end

    // Operand registers double as the ALU drive, so the ALU inputs only move on acceptance.
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    // The ALU result is only present during WB; the held copy covers the gaps between pulses.
    assign bus.ins_ready = ins_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_valid_q ? alu_ans : res_data_q;
    assign bus.res_zero  = res_valid_q ? alu_zero : res_zero_q;
    assign bus.res_rd    = res_rd_q;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: a behavioural registered ALU closes the loop, a
// reference register file predicts every result, and a scoreboard queue
// matches each res_valid pulse against the prediction made at acceptance.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      alu_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_ans;
    logic            alu_zero;

    alu_issue_if bus();

    alu_issue dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ans  (alu_ans),
        .alu_zero (alu_zero)
    );

    always #5 clk = ~clk;

`ifdef ISSUE_BYPASS_EN
    localparam int EXP_SPACING = 2;
`else
    localparam int EXP_SPACING = 3;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          zero;
        logic [AW-1:0] rd;
        bit            dataCare;
        int            acceptCycle;
    } expect_t;

    expect_t        expQ[$];
    logic [DW-1:0]  refRegs [NREGS];
    int             cycleCount = 0;
    int             errorCount = 0;
    int             checkCount = 0;
    int             lastAcceptCycle = 0;
    int             prevAcceptCycle = 0;
    logic [DW-1:0]  lastResData = '0;
    logic [AW-1:0]  lastResRd = '0;

    // Reference ALU behaviour: wrap-around arithmetic, 0/1 compares, unknown op gives 0.
    function automatic logic [DW-1:0] aluModel(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b110:  return (a < b) ? DW'(1) : DW'(0);
            3'b111:  return (a == '0) ? DW'(1) : DW'(0);
            default: return '0;
        endcase
    endfunction

    // Cycle counter used for latency and spacing measurements.
    always @(posedge clk) cycleCount++;

    // Behavioural one-cycle registered ALU.
    always @(posedge clk) begin
        if (rst) begin
            alu_ans  <= '0;
            alu_zero <= 1'b1;
        end else begin
            alu_ans  <= aluModel(alu_op, alu_a, alu_b);
            alu_zero <= (aluModel(alu_op, alu_a, alu_b) == '0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && bus.res_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                if (e.dataCare) begin
                    checkOutput("res_data", 32'(bus.res_data), 32'(e.data));
                    checkOutput("res_zero", 32'(bus.res_zero), 32'(e.zero));
                end
                checkOutput("res_rd", 32'(bus.res_rd), 32'(e.rd));
                checkOutput("latency", 32'(cycleCount - e.acceptCycle), 32'd2);
                lastResData = bus.res_data;
                lastResRd   = bus.res_rd;
            end
        end
    end

    task automatic clearModel();
        for (int i = 0; i < NREGS; i++) refRegs[i] = '0;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic [DW-1:0] imm, input logic useImm, input logic [AW-1:0] rd,
                                 input logic wb, input bit expectResult);
        int waited;
        logic [DW-1:0] opA;
        logic [DW-1:0] opB;
        logic [DW-1:0] r;
        expect_t e;
        @(negedge clk);
        bus.ins_op      = op;
        bus.ins_rs      = rs;
        bus.ins_rt      = rt;
        bus.ins_imm     = imm;
        bus.ins_use_imm = useImm;
        bus.ins_rd      = rd;
        bus.ins_wb      = wb;
        bus.ins_valid   = 1'b1;
        waited = 0;
        while (bus.ins_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checkOutput("ins_ready_timeout", 32'd0, 32'd1);
            bus.ins_valid = 1'b0;
            return;
        end
        opA = refRegs[rs];
        opB = useImm ? imm : refRegs[rt];
        r   = aluModel(op, opA, opB);
        prevAcceptCycle = lastAcceptCycle;
        lastAcceptCycle = cycleCount;
        if (expectResult) begin
            e.data        = r;
            e.zero        = (r == '0);
            e.rd          = rd;
            e.dataCare    = (op != 3'b101);
            e.acceptCycle = cycleCount;
            expQ.push_back(e);
            if (wb && rd != '0) refRegs[rd] = r;
        end
        @(posedge clk);
        #1;
        bus.ins_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
    endtask

    initial begin
        bus.ins_valid   = 1'b0;
        bus.ins_op      = '0;
        bus.ins_rs      = '0;
        bus.ins_rt      = '0;
        bus.ins_imm     = '0;
        bus.ins_use_imm = 1'b0;
        bus.ins_rd      = '0;
        bus.ins_wb      = 1'b0;
        clearModel();

        // Reset held two cycles, then every output at its reset value.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ins_ready", 32'(bus.ins_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_res_data",  32'(bus.res_data),  32'd0);
        checkOutput("rst_res_zero",  32'(bus.res_zero),  32'd0);
        checkOutput("rst_res_rd",    32'(bus.res_rd),    32'd0);
        checkOutput("rst_alu_op",    32'(alu_op),        32'd0);
        checkOutput("rst_alu_a",     32'(alu_a),         32'd0);
        checkOutput("rst_alu_b",     32'(alu_b),         32'd0);
        applyStimulus(3'b011, 3'd7, 3'd6, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
        waitDrain();

        // Basic ADD / SUB through the register file.
        applyStimulus(3'b000, 3'd0, 3'd0, 8'h05, 1'b1, 3'd1, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b001, 3'd1, 3'd0, 8'h07, 1'b1, 3'd2, 1'b1, 1'b1);
        waitDrain();

        // Wrap-around, SLT, BZ and register-register logic ops.
        applyStimulus(3'b000, 3'd0, 3'd0, 8'hFF, 1'b1, 3'd4, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b000, 3'd4, 3'd0, 8'h01, 1'b1, 3'd3, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b000, 3'd0, 3'd0, 8'h03, 1'b1, 3'd5, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b110, 3'd5, 3'd0, 8'h04, 1'b1, 3'd6, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b111, 3'd0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b010, 3'd2, 3'd4, 8'h00, 1'b0, 3'd6, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b100, 3'd1, 3'd2, 8'h00, 1'b0, 3'd7, 1'b1, 1'b1);
        waitDrain();

        // Flags-only compare and a write to R0 must leave the register file alone.
        applyStimulus(3'b001, 3'd1, 3'd1, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(3'b000, 3'd1, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b000, 3'd0, 3'd0, 8'h33, 1'b1, 3'd0, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b011, 3'd0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1);
        waitDrain();

        // Undefined op still produces a pulse and the stage keeps going.
        applyStimulus(3'b101, 3'd1, 3'd2, 8'h00, 1'b0, 3'd5, 1'b0, 1'b1);
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("res_data_hold", 32'(bus.res_data), 32'(lastResData));
        checkOutput("res_rd_hold",   32'(bus.res_rd),   32'(lastResRd));

        // Reset during EXEC aborts: no pulse, no write, clean restart.
        applyStimulus(3'b000, 3'd0, 3'd0, 8'h44, 1'b1, 3'd4, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clearModel();
        repeat (4) @(negedge clk);
        applyStimulus(3'b000, 3'd4, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 1'b1);
        waitDrain();

        // Back-to-back dependent instructions: spacing and forwarded values.
        applyStimulus(3'b000, 3'd0, 3'd0, 8'h10, 1'b1, 3'd1, 1'b1, 1'b1);
        applyStimulus(3'b000, 3'd1, 3'd0, 8'h01, 1'b1, 3'd2, 1'b1, 1'b1);
        checkOutput("issue_spacing", 32'(lastAcceptCycle - prevAcceptCycle), 32'(EXP_SPACING));
        applyStimulus(3'b000, 3'd2, 3'd2, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(3'b000, 3'd4, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 1'b1);
        waitDrain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
